// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line parameters
// and 8N1 frame constants used by both uart_recv and uart_send.
package uart_pkg;

    localparam int DEF_CLK_FREQ  = 100_000_000;
    localparam int DEF_BAUD_RATE = 9600;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset value
// is a parameter so the output starts at the line's idle level.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: synchronises din, rejects short start glitches, samples
// each bit at its midpoint and strobes valid or frame_err once per frame.
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEF_CLK_FREQ,
    parameter int BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic                 valid,
    output logic [DATA_BITS-1:0] data,
    output logic                 frame_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_recv: CLKS_PER_BIT must be >= 4");
        end
    endgenerate

    rx_state_t            state_r;
    rx_state_t            state_nxt_s;
    logic                 rxd_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 ferr_r;
    logic                 bit_done_s;
    logic                 half_done_s;
    logic                 cnt_clr_s;
    logic                 idx_clr_s;
    logic                 shift_en_s;
    logic                 valid_set_s;
    logic                 ferr_set_s;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (rxd_s)
    );

    assign bit_done_s  = (cnt_r == BIT_LAST);
    assign half_done_s = (cnt_r == HALF_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (rxd_s == 1'b0) state_nxt_s = START;
                else               state_nxt_s = IDLE;
            end
            START: begin
                if (!half_done_s)       state_nxt_s = START;
                else if (rxd_s == 1'b1) state_nxt_s = IDLE;
                else                    state_nxt_s = DATA;
            end
            DATA: begin
                if (bit_done_s && idx_r == IDX_LAST) state_nxt_s = STOP;
                else                                  state_nxt_s = DATA;
            end
            STOP: begin
                if (!bit_done_s)               state_nxt_s = STOP;
                else if (rxd_s == STOP_LEVEL)  state_nxt_s = IDLE;
                else                           state_nxt_s = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                // A held-low break must end before a new start edge is accepted
                if (rxd_s == 1'b1) state_nxt_s = IDLE;
                else               state_nxt_s = WAIT_IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath control decode
    always_comb begin
        cnt_clr_s   = 1'b0;
        idx_clr_s   = 1'b0;
        shift_en_s  = 1'b0;
        valid_set_s = 1'b0;
        ferr_set_s  = 1'b0;
        case (state_r)
            IDLE:      cnt_clr_s = 1'b1;
            START: begin
                if (half_done_s) begin
                    cnt_clr_s = 1'b1;
                    idx_clr_s = 1'b1;
                end else begin
                    cnt_clr_s = 1'b0;
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    cnt_clr_s  = 1'b1;
                    shift_en_s = 1'b1;
                end else begin
                    cnt_clr_s = 1'b0;
                end
            end
            STOP: begin
                if (bit_done_s) begin
                    cnt_clr_s   = 1'b1;
                    valid_set_s = (rxd_s == STOP_LEVEL);
                    ferr_set_s  = (rxd_s != STOP_LEVEL);
                end else begin
                    cnt_clr_s = 1'b0;
                end
            end
            WAIT_IDLE: cnt_clr_s = 1'b1;
            default:   cnt_clr_s = 1'b1;
        endcase
    end

    // Baud counter, bit index, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            if (cnt_clr_s) cnt_r <= '0;
            else           cnt_r <= cnt_r + CNT_W'(1);

            if (idx_clr_s)       idx_r <= '0;
            else if (shift_en_s) idx_r <= idx_r + IDX_W'(1);

            // LSB arrives first, so shift right and insert at the top
            if (shift_en_s) shift_r <= {rxd_s, shift_r[DATA_BITS-1:1]};

            if (valid_set_s) data_r <= shift_r;

            valid_r <= valid_set_s;
            ferr_r  <= ferr_set_s;
        end
    end

    assign valid     = valid_r;
    assign data      = data_r;
    assign frame_err = ferr_r;

endmodule

// File: tb/tb_uart_recv.sv
// Scoreboard bench for uart_recv at CLKS_PER_BIT=16: stimulus pushes expected
// bytes and strobe times, an independent monitor pops and compares.
module tb_uart_recv;
    import uart_pkg::*;

    localparam int CPB     = 16;
    localparam int LATENCY = 2 + 8 + 8 * 16 + 16 + 1;

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic       valid;
    logic [7:0] data;
    logic       frame_err;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   valid_cnt = 0;
    int   ferr_cnt = 0;
    int   exp_valid = 0;
    logic [7:0] last_good = 8'h00;
    logic prev_strobe = 1'b0;
    exp_t vq[$];
    exp_t fq[$];

    uart_recv #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .valid     (valid),
        .data      (data),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one 8N1 frame; optionally register its expected outcome
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic track);
        exp_t e;
        @(negedge clk);
        e.b = b;
        e.t = cyc;
        if (track) begin
            if (stop_bit) begin
                vq.push_back(e);
                last_good = b;
                exp_valid++;
            end else begin
                e.b = last_good;
                fq.push_back(e);
            end
        end
        din = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            repeat (CPB) @(negedge clk);
        end
        din = stop_bit;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        din = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compare every strobe against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (valid && frame_err) check("strobe_exclusive", 32'd1, 32'd0);
            if ((valid || frame_err) && prev_strobe) check("strobe_back_to_back", 32'd1, 32'd0);
            if (valid) begin
                valid_cnt++;
                if (vq.size() == 0) begin
                    check("unexpected_valid", {24'd0, data}, 32'hFFFF_FFFF);
                end else begin
                    e = vq.pop_front();
                    check("valid_data", {24'd0, data}, {24'd0, e.b});
                    check("valid_latency_ok", {31'd0, ((cyc - e.t) >= LATENCY - 1) && ((cyc - e.t) <= LATENCY + 1)}, 32'd1);
                end
            end
            if (frame_err) begin
                ferr_cnt++;
                if (fq.size() == 0) begin
                    check("unexpected_frame_err", 32'd1, 32'd0);
                end else begin
                    e = fq.pop_front();
                    check("ferr_data_held", {24'd0, data}, {24'd0, e.b});
                end
            end
            prev_strobe = valid || frame_err;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    initial begin
        logic [7:0] rb;
        int gap;
        int vsnap;
        int fsnap;

        repeat (3) @(negedge clk);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_ferr", {31'd0, frame_err}, 32'd0);
        check("reset_data", {24'd0, data}, 32'd0);
        rst = 1'b0;
        idle(10);

        send_byte(8'h73, 1'b1, 1'b1);
        idle(20);

        send_byte(8'h68, 1'b1, 1'b1);
        send_byte(8'h69, 1'b1, 1'b1);
        idle(20);

        vsnap = valid_cnt;
        fsnap = ferr_cnt;
        din = 1'b0;
        repeat (5) @(negedge clk);
        idle(30);
        check("glitch_no_valid", valid_cnt, vsnap);
        check("glitch_no_ferr", ferr_cnt, fsnap);
        check("glitch_state_idle", {29'd0, dut.state_r}, {29'd0, IDLE});
        send_byte(8'h0D, 1'b1, 1'b1);
        idle(20);

        vsnap = valid_cnt;
        send_byte(8'h55, 1'b0, 1'b1);
        din = 1'b0;
        repeat (100) @(negedge clk);
        idle(20);
        check("ferr_count", ferr_cnt, 1);
        check("ferr_no_valid", valid_cnt, vsnap);
        check("ferr_data_kept", {24'd0, data}, 32'h0000_000D);
        send_byte(8'h0A, 1'b1, 1'b1);
        idle(20);

        vsnap = valid_cnt;
        fsnap = ferr_cnt;
        fork
            send_byte(8'hFF, 1'b1, 1'b0);
            begin
                repeat (80) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        idle(40);
        last_good = 8'h00;
        check("midreset_no_valid", valid_cnt, vsnap);
        check("midreset_no_ferr", ferr_cnt, fsnap);
        check("midreset_data", {24'd0, data}, 32'd0);
        send_byte(8'h7A, 1'b1, 1'b1);
        idle(20);

        for (int k = 0; k < 200; k++) begin
            rb = 8'($urandom_range(0, 255));
            send_byte(rb, 1'b1, 1'b1);
            gap = $urandom_range(0, 40);
            idle(gap + 1);
        end

        for (int w = 0; w < 500 && (vq.size() != 0 || fq.size() != 0); w++) @(negedge clk);
        check("scoreboard_drained", vq.size() + fq.size(), 0);
        check("total_valid", valid_cnt, exp_valid);
        check("total_valid_206", exp_valid, 206);
        check("total_ferr", ferr_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- 8N1 UART receiver: serial line in; one byte plus a single-cycle valid strobe out.
- Sits upstream of the string-matching FSM and drives its valid/recv_data inputs.
- Counterpart of uart_send; same clock and same baud parameters.
- Includes input synchronisation, start-bit glitch rejection, mid-bit sampling and stop-bit framing check.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE, derived localparam; must be >= 4 (elaboration error otherwise).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- din  input  1  asynchronous serial line, idle high.
- valid  output  1  one-cycle strobe; data is a new good byte.
- data  output  8  last good byte; held until next good byte.
- frame_err  output  1  one-cycle strobe; stop bit sampled low.

Behaviour:
- Reset (synchronous, active-high, one clock; clk and rst as above):
  - state=IDLE, counters=0, shift register=0.
  - valid=0, frame_err=0, data=8'h00.
  - Synchroniser flops reset to 1 (idle line).
- din passes through a 2-flop synchroniser; all logic uses the synchronised value rxd (2-cycle input latency).
- Baud counter cnt counts 0..limit, restarts at 0 on each state entry. Bit index idx is 0..7.
- States:
  - IDLE: when rxd==0 -> START, cnt=0.
  - START: when cnt==CLKS_PER_BIT/2-1, sample rxd.
    - rxd==1 -> IDLE (glitch; no strobe).
    - rxd==0 -> DATA, cnt=0, idx=0.
  - DATA: when cnt==CLKS_PER_BIT-1, sample rxd into shift register.
    - LSB first: shift right, new bit into bit 7.
    - idx==7 -> STOP; else idx+1.
  - STOP: when cnt==CLKS_PER_BIT-1, sample rxd.
    - rxd==1 -> data<=shifted byte, valid=1 for exactly one cycle, -> IDLE.
    - rxd==0 -> frame_err=1 for one cycle, data unchanged, -> WAIT_IDLE.
  - WAIT_IDLE: stay until rxd==1, then -> IDLE. Prevents a held-low break from being decoded as 0x00 frames.
- Sampling lands at mid-bit. valid rises in the cycle after the stop-bit midpoint sample, so a back-to-back next start bit (1/2 bit later) is never missed.
- valid and frame_err are registered, mutually exclusive, and never asserted two cycles in a row.
- Reset mid-frame aborts the frame: no valid, no frame_err; data returns to 0.
- Line rate mismatch is not tracked: there is no drift correction beyond per-frame resynchronisation on the start edge.

Decomposition:
- Shared package uart_pkg:
  - rx state enum localparams: IDLE, START, DATA, STOP, WAIT_IDLE (3-bit).
  - Default CLK_FREQ/BAUD_RATE constants, shared with uart_send.
  - Frame constants: DATA_BITS=8, STOP_LEVEL=1'b1.
- One natural sub-module: uart_sync2 (2-flop synchroniser, reset value parameterised). Instantiated once.
- Counters and FSM stay in uart_recv.

Test Plan (bench uses CLK_FREQ=16, BAUD_RATE=1, so CLKS_PER_BIT=16):
- Send 8'h73 ('s') as a clean 8N1 frame -> exactly one valid pulse with data=8'h73. valid rises 2+8+8*16+16+1 cycles after the start edge ±1; frame_err stays 0.
- Send 8'h68, 8'h69 back-to-back with no idle gap -> two valid pulses, data 8'h68 then 8'h69, 160 cycles apart.
- Pulse din low for 5 cycles, then high -> no valid, no frame_err; FSM back in IDLE. A following 8'h0D frame is received correctly.
- Send 8'h55 with stop bit 0, hold line low 100 cycles, release -> one frame_err pulse, no valid, data keeps its previous value. Next frame 8'h0A is received as 8'h0A, not 8'h00.
- Assert rst for one cycle midway through the data bits of 8'hFF -> valid/frame_err stay 0, data=8'h00. A subsequent 8'h7A frame is received correctly.
- Random 200 bytes with idle gaps of 0..40 cycles -> every byte matches in order; valid count equals 200, frame_err count 0.
